// File: rtl/adder_pipe.sv
// Pipelined ADD/SUB/ADC/SBC with NZCV flags; STAGES-cycle latency, 1 op/cycle, global stall when the output is held.
// Optional ADDER_PIPE_FLUSH_EN adds a flush input that drops every in-flight operation.
module adder_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
`ifdef ADDER_PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int SW = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic             w_adv;
  logic             w_step;
  logic             w_seed;
  logic [WIDTH-1:0] w_b_eff;

  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_c   [STAGES];
  logic             r_ovf;

  logic             w_src_vld [STAGES];
  logic [WIDTH-1:0] w_src_a   [STAGES];
  logic [WIDTH-1:0] w_src_b   [STAGES];
  logic [WIDTH-1:0] w_src_s   [STAGES];
  logic             w_src_c   [STAGES];
  logic [SW:0]      w_add     [STAGES];
  logic [WIDTH-1:0] w_nxt_s   [STAGES];
  logic             w_ovf_nxt;

  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

`ifdef ADDER_PIPE_FLUSH_EN
  assign w_step = w_adv & ~flush;
`else
  assign w_step = w_adv;
`endif

  // SUB/SBC add the inverted operand; the +1 of two's complement comes in as the carry seed.
  assign w_b_eff = op[0] ? ~b : b;
  assign w_seed  = op[1] ? cin : op[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_merged;

    if (k == 0) begin : g_head
      assign w_src_vld[k] = in_valid;
      assign w_src_a[k]   = a;
      assign w_src_b[k]   = w_b_eff;
      assign w_src_s[k]   = '0;
      assign w_src_c[k]   = w_seed;
    end else begin : g_body
      assign w_src_vld[k] = r_vld[k-1];
      assign w_src_a[k]   = r_a[k-1];
      assign w_src_b[k]   = r_b[k-1];
      assign w_src_s[k]   = r_s[k-1];
      assign w_src_c[k]   = r_c[k-1];
    end

    assign w_add[k] = {1'b0, w_src_a[k][k*SW +: SW]}
                    + {1'b0, w_src_b[k][k*SW +: SW]}
                    + {{SW{1'b0}}, w_src_c[k]};

    always_comb begin
      w_merged = w_src_s[k];
      w_merged[k*SW +: SW] = w_add[k][SW-1:0];
    end
    assign w_nxt_s[k] = w_merged;

    if (k == STAGES - 1) begin : g_tail
      // a^b^sum at the MSB recovers the carry into it; V is that XOR the carry out.
      assign w_ovf_nxt = w_src_a[k][WIDTH-1] ^ w_src_b[k][WIDTH-1]
                       ^ w_add[k][SW-1] ^ w_add[k][SW];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_s[k]   <= '0;
        r_c[k]   <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else begin
      if (w_step) begin
        for (int k = 0; k < STAGES; k++) begin
          r_vld[k] <= w_src_vld[k];
          r_a[k]   <= w_src_a[k];
          r_b[k]   <= w_src_b[k];
          r_s[k]   <= w_nxt_s[k];
          r_c[k]   <= w_add[k][SW];
        end
        r_ovf <= w_ovf_nxt;
      end
`ifdef ADDER_PIPE_FLUSH_EN
      if (flush) begin
        for (int k = 0; k < STAGES; k++) begin
          r_vld[k] <= 1'b0;
        end
      end
`endif
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign result    = r_s[STAGES-1];
  assign carry_out = r_c[STAGES-1];
  assign overflow  = r_ovf;
  assign negative  = result[WIDTH-1];
  assign zero      = ~|result;

endmodule

// File: tb/tb_adder_pipe.sv
// Randomised and directed bench for adder_pipe against an integer-arithmetic reference model.
module tb_adder_pipe;
  localparam int W = 64;
  localparam int S = 4;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   nzcv;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         cin = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef ADDER_PIPE_FLUSH_EN
  logic         flush = 1'b0;
`endif
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         negative;
  logic         zero;
  logic         overflow;
  logic         carry_out;

  int           n_checks = 0;
  int           n_fails = 0;
  int           stall_seen = 0;
  exp_t         exp_q[$];
  logic [W-1:0] rec_q[$];
  bit           rec_en = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_res;
  logic [3:0]   prev_nzcv;

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef ADDER_PIPE_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  // Reference: treat operands as mathematical integers, then read the flags off the exact sums.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c);
    logic signed [W+3:0] ux, uy, sx, sy, ci, ut, st, sfit;
    logic cs, cflag;
    exp_t e;
    cs = (o == 2'b00) ? 1'b0 : (o == 2'b01) ? 1'b1 : c;
    ux = {4'b0, x};
    uy = {4'b0, y};
    sx = $signed(x);
    sy = $signed(y);
    ci = {{(W+3){1'b0}}, cs};
    if (!o[0]) begin
      ut = ux + uy + ci;
      st = sx + sy + ci;
      cflag = ut[W];
    end else begin
      ut = ux - uy - 1 + ci;
      st = sx - sy - 1 + ci;
      cflag = (ut >= 0);
    end
    e.res  = ut[W-1:0];
    sfit   = $signed(st[W-1:0]);
    e.nzcv = {e.res[W-1], (e.res == '0), cflag, (st != sfit)};
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      4:       return {32'h0, 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Scoreboard: sample between edges, retire outputs first, then log newly accepted ops.
  always @(negedge clk) begin
    logic fl;
    exp_t e;
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      fl = 1'b0;
`ifdef ADDER_PIPE_FLUSH_EN
      fl = flush;
`endif
      if (prev_stall) begin
        check_val("stall_vld", out_valid, 1);
        check_val("stall_res", result, prev_res);
        check_val("stall_flg", {negative, zero, carry_out, overflow}, prev_nzcv);
      end
      if (out_valid && !out_ready) begin
        check_val("bp_in_ready", in_ready, 0);
        if (rec_en) stall_seen++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("sb_res", result, e.res);
          check_val("sb_nzcv", {negative, zero, carry_out, overflow}, e.nzcv);
        end
        if (rec_en) rec_q.push_back(result);
      end
      if (fl) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(op, a, b, cin));
      prev_stall = out_valid && !out_ready && !fl;
      prev_res   = result;
      prev_nzcv  = {negative, zero, carry_out, overflow};
    end
  end

  task automatic run_one(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic c,
                         input logic [W-1:0] er, input logic [3:0] enzcv);
    int lat;
    bit got;
    @(posedge clk); #1;
    op = o; a = x; b = y; cin = c; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1'b1;
    end
    check_val({tag, "_lat"}, lat, S);
    check_val({tag, "_res"}, result, er);
    check_val({tag, "_nzcv"}, {negative, zero, carry_out, overflow}, enzcv);
    @(posedge clk);
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 60 && exp_q.size() != 0; t++) @(negedge clk);
    check_val(tag, exp_q.size(), 0);
  endtask

  initial begin
    #3;
    check_val("rst_vld", out_valid, 0);
    check_val("rst_res", result, 0);
    check_val("rst_flags", {negative, zero, carry_out, overflow}, 4'b0100);
    check_val("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_one("add",     2'b00, 64'd5, 64'd7, 1'b0, 64'd12, 4'b0000);
    run_one("sub_eq",  2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 4'b0110);
    run_one("add_ovf", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001);
    run_one("add_wrap",2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0110);
    run_one("add_xing",2'b00, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h1_0000_0000, 4'b0000);
    run_one("adc",     2'b10, 64'd1, 64'd1, 1'b1, 64'd3, 4'b0000);
    run_one("sbc",     2'b11, 64'd5, 64'd3, 1'b0, 64'd1, 4'b0010);

    // Six back-to-back adds with a three-cycle output stall in the middle.
    rec_q.delete();
    stall_seen = 0;
    rec_en = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int  tries;
          bit  acc;
          tries = 0;
          acc = 1'b0;
          op = 2'b00; a = W'(i); b = W'(i); cin = 1'b0; in_valid = 1'b1;
          while (!acc && tries < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            tries++;
          end
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    rec_en = 1'b0;
    check_val("bp_stalls", stall_seen, 3);
    check_val("bp_count", rec_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rec_q.size()) check_val($sformatf("bp_out%0d", i), rec_q[i], W'(2 * i));
    end

    // Reset with three ops in flight, the oldest already presented at the output.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      op = 2'b00; a = W'(100 + i); b = W'(1); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_val("pre_rst_vld", out_valid, 1);
    #1 reset = 1'b1;
    #1;
    check_val("midrst_vld", out_valid, 0);
    check_val("midrst_res", result, 0);
    check_val("midrst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check_val("stale_after_rst", out_valid, 0);
    end

`ifdef ADDER_PIPE_FLUSH_EN
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      op = 2'b00; a = W'(200 + i); b = W'(1); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    a = W'(300); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check_val("flush_vld", out_valid, 0);
    check_val("flush_in_ready", in_ready, 1);
    repeat (8) begin
      @(negedge clk);
      check_val("stale_after_flush", out_valid, 0);
    end
`endif

    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 2'($urandom);
      a         = pick();
      b         = pick();
      cin       = 1'($urandom);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined add/subtract unit with ARM-style NZCV flags.
- Successor to the single-cycle 64-bit ripple adder: generalised WIDTH, carry chain split across STAGES register stages, four operations (ADD/SUB/ADC/SBC), valid/ready handshake with backpressure.
- Sits in the EX stage as the arithmetic core behind ADDS/SUBS/ADCS/SBCS and CMP.

Parameters:
- WIDTH, 64, operand/result width in bits.
- STAGES, 4, pipeline depth = latency in cycles; each stage adds a WIDTH/STAGES-bit slice. WIDTH % STAGES must be 0; STAGES >= 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/op valid this cycle.
- in_ready  output  1  unit accepts an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  00 ADD a+b; 01 SUB a+~b+1; 10 ADC a+b+cin; 11 SBC a+~b+cin.
- cin  input  1  carry flag in, used only by ADC/SBC.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum.
- negative  output  1  result[WIDTH-1].
- zero  output  1  result == 0.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- carry_out  output  1  carry out of MSB (SUB/SBC: 1 = no borrow).

Behaviour:
- Global advance: adv = out_ready | ~out_valid; in_ready = adv (combinational). No bubble collapsing; all stages move together.
- Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
- On adv: stage 0 captures a, b_eff (b or ~b), carry seed (ADD 0, SUB 1, ADC/SBC cin) and valid=in_valid. Each stage k adds slice k using the carry registered by stage k-1 and forwards the unprocessed upper slices. Final stage registers result, carry_out, overflow. When adv=0 all stage registers hold.
- Latency exactly STAGES cycles from accept to out_valid with out_ready held 1; throughput 1 op/cycle.
- negative and zero derived from the registered final result; they are valid only while out_valid=1 but are always driven.
- Overflow uses carry into bit WIDTH-1, not a sign-compare shortcut.
- STAGES=1: single registered adder, latency 1.
- Reset (async, any time, including mid-stall): all valid bits 0, all data/carry registers 0. Outputs after reset: out_valid=0, result=0, negative=0, zero=1 (result 0), overflow=0, carry_out=0, in_ready=1. In-flight operations are discarded.
- Backpressure: while out_valid=1 and out_ready=0, result and flags are stable and in_ready=0.
- in_valid=0 while adv=1 inserts a bubble; downstream never sees a duplicate.

Optional Feature:
- Macro ADDER_PIPE_FLUSH_EN adds input port flush (1 bit).
- With it: flush=1 at a rising edge clears every stage valid bit; data registers are left as-is. Flush overrides adv and same-cycle acceptance: an op offered with flush=1 is dropped. in_ready=1 on the cycle after flush.
- Without it: no flush port; pipeline is emptied only by reset or draining.

Test Plan:
- Reset then ADD, WIDTH=64, STAGES=4: a=5, b=7 -> after 4 cycles out_valid=1, result=12, NZCV=0000.
- SUB equal operands: a=b=0x8000_0000_0000_0000 -> result=0, Z=1, C=1, V=0, N=0.
- Signed overflow: ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result=0x8000_0000_0000_0000, N=1, V=1, C=0. Unsigned wrap: ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, Z=1, C=1, V=0. Carry crossing stage boundaries: ADD a=0x0000_0000_FFFF_FFFF, b=1 -> result=0x1_0000_0000.
- ADC/SBC: ADC 1+1 with cin=1 -> 3. SBC a=5, b=3, cin=0 -> result=1, C=1.
- Backpressure: stream 6 back-to-back ADDs (i+i, i=0..5) and hold out_ready=0 for 3 cycles mid-stream -> outputs 0,2,4,6,8,10 in order, no loss or duplication, result stable while stalled, in_ready=0 during the stall.
- Assert reset with 3 ops in flight -> out_valid=0 immediately, no stale result after release. With ADDER_PIPE_FLUSH_EN, flush pulse gives the same result, and reset values apply only to valid bits.
